// File: rtl/hazard_issue_scheduler.sv
// hazard_issue_scheduler
//
// Sits between the instruction source and Control and inserts NOP bubbles
// for read-after-write hazards, so programs no longer need hand-placed NOPs.
// A per-register scoreboard counts the cycles until each pending write is
// visible; an instruction whose source is still pending waits in a
// one-entry holding register while the canonical NOP is issued instead.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   in_instr    candidate instruction from fetch/ROM
//   in_valid    in_instr is valid
//   in_ready    scheduler accepts in_instr this cycle (combinational)
//   out_instr   registered instruction to Control
//   out_valid   out_instr is a real accepted instruction
//   out_bubble  out_instr is a NOP inserted for a hazard
//   stall_count (only with SCHED_STALL_COUNT_EN) saturating bubble count
//
// Optional feature macro: SCHED_STALL_COUNT_EN adds the stall_count port.
module hazard_issue_scheduler #(
  parameter int ALU_LATENCY  = 3,
  parameter int LOAD_LATENCY = 3,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_instr,
  output logic        out_valid,
  output logic        out_bubble
`ifdef SCHED_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam logic [31:0] NOP_INSTR = {6'b000100, 5'd0, 5'd0, 5'd0, 5'b01010, 6'b000000};
  localparam logic [5:0]  OP_R      = 6'b000100;
  localparam logic [5:0]  OP_LW     = 6'b000101;
  localparam logic [5:0]  OP_SW     = 6'b000110;
  localparam logic [CNT_W-1:0] ALU_LAT  = CNT_W'(ALU_LATENCY);
  localparam logic [CNT_W-1:0] LOAD_LAT = CNT_W'(LOAD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      hold_instr_reg;
  logic             hold_valid_reg;
  logic [CNT_W-1:0] cnt [32];

  // Decode of the held instruction
  logic [5:0]       opcode;
  logic [4:0]       field_a;
  logic [4:0]       field_b;
  logic [4:0]       field_rd;
  logic [5:0]       funct;
  logic             use_a;
  logic             use_b;
  logic             has_dest;
  logic [4:0]       dest;
  logic [CNT_W-1:0] dest_lat;

  assign opcode   = hold_instr_reg[31:26];
  assign field_a  = hold_instr_reg[25:21];
  assign field_b  = hold_instr_reg[20:16];
  assign field_rd = hold_instr_reg[15:11];
  assign funct    = hold_instr_reg[5:0];

  always_comb begin
    use_a    = 1'b0;
    use_b    = 1'b0;
    has_dest = 1'b0;
    dest     = 5'd0;
    dest_lat = '0;
    case (opcode)
      OP_R: begin
        // funct 000000 is the NOP encoding: no sources, no destination
        if (funct != 6'b000000) begin
          use_a    = 1'b1;
          use_b    = 1'b1;
          has_dest = 1'b1;
          dest     = field_rd;
          dest_lat = ALU_LAT;
        end
      end
      OP_LW: begin
        use_b    = 1'b1;
        has_dest = 1'b1;
        dest     = field_a;
        dest_lat = LOAD_LAT;
      end
      OP_SW: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      default: ;
    endcase
  end

  logic hazard;
  logic issue;
  logic accept;

  // Sources are checked against the scoreboard as it stands before this
  // instruction's own destination is marked, so lw $s0,0($s0) is not
  // blocked by itself.
  assign hazard   = hold_valid_reg &&
                    ((use_a && (cnt[field_a] != '0)) || (use_b && (cnt[field_b] != '0)));
  assign issue    = hold_valid_reg && !hazard;
  assign in_ready = !hold_valid_reg || issue;
  assign accept   = in_valid && in_ready;

  // Scoreboard: one down-counter per register, reg 0 included
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_dec;
      logic [CNT_W-1:0] cnt_next;

      assign cnt_dec = (cnt_reg != '0) ? (cnt_reg - CNT_ONE) : '0;

      always_comb begin
        cnt_next = cnt_dec;
        // A new write keeps whichever wait is longer (WAW reload)
        if (issue && has_dest && (dest == 5'(gi)))
          cnt_next = (cnt_dec > dest_lat) ? cnt_dec : dest_lat;
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_reg <= '0;
        else     cnt_reg <= cnt_next;
      end

      assign cnt[gi] = cnt_reg;
    end
  endgenerate

  // Holding register and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_instr_reg <= NOP_INSTR;
      hold_valid_reg <= 1'b0;
      out_instr      <= NOP_INSTR;
      out_valid      <= 1'b0;
      out_bubble     <= 1'b0;
    end else begin
      if (accept) begin
        hold_instr_reg <= in_instr;
        hold_valid_reg <= 1'b1;
      end else if (issue) begin
        hold_valid_reg <= 1'b0;
      end

      if (issue) begin
        out_instr  <= hold_instr_reg;
        out_valid  <= 1'b1;
        out_bubble <= 1'b0;
      end else begin
        out_instr  <= NOP_INSTR;
        out_valid  <= 1'b0;
        out_bubble <= hold_valid_reg;
      end
    end
  end

`ifdef SCHED_STALL_COUNT_EN
  // Counts edges that register a bubble; saturates rather than wrapping
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= 16'd0;
    else if (hold_valid_reg && !issue && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_issue_scheduler.sv
module tb_hazard_issue_scheduler;

  localparam logic [31:0] NOP = {6'b000100, 5'd0, 5'd0, 5'd0, 5'b01010, 6'b000000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_instr = NOP;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready2;
  logic [31:0] out_instr, out_instr2;
  logic        out_valid, out_valid2;
  logic        out_bubble, out_bubble2;
`ifdef SCHED_STALL_COUNT_EN
  logic [15:0] stall_count, stall_count2;
`endif

  always #5 clk = ~clk;

  hazard_issue_scheduler dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_instr(out_instr), .out_valid(out_valid),
    .out_bubble(out_bubble)
`ifdef SCHED_STALL_COUNT_EN
    , .stall_count(stall_count)
`endif
  );

  hazard_issue_scheduler #(.ALU_LATENCY(1)) dut_alu1 (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready2), .out_instr(out_instr2), .out_valid(out_valid2),
    .out_bubble(out_bubble2)
`ifdef SCHED_STALL_COUNT_EN
    , .stall_count(stall_count2)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rt(input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] d, input logic [5:0] f);
    return {6'b000100, a, b, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] a, input logic [4:0] b);
    return {6'b000101, a, b, 16'h0000};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] a, input logic [4:0] b);
    return {6'b000110, a, b, 16'h0000};
  endfunction

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic [31:0] instr;
    logic        ck_rdy;
    logic        rdy;
    logic [31:0] o_instr;
    logic        o_vld;
    logic        o_bub;
    int          sc;      // expected stall_count after the edge, -1 = skip
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input string name, input logic r, input logic vl,
                            input logic [31:0] ins, input logic ck, input logic rdy,
                            input logic [31:0] oi, input logic ov, input logic ob,
                            input int sc);
    vec_t t;
    t.name = name; t.rst = r; t.vld = vl; t.instr = ins; t.ck_rdy = ck; t.rdy = rdy;
    t.o_instr = oi; t.o_vld = ov; t.o_bub = ob; t.sc = sc;
    vecs.push_back(t);
  endfunction

  task automatic drive(input logic r, input logic vl, input logic [31:0] ins);
    @(negedge clk);
    rst = r; in_valid = vl; in_instr = ins;
  endtask

  initial begin
    logic [31:0] l16, l17, l18, l19, lw4, sub, add5, sw5, lw4b, mul4, rd4, lw00, add0;
    int bubbles;
    l16 = lw(16, 0); l17 = lw(17, 0); l18 = lw(18, 0); l19 = lw(19, 0);
    lw4 = lw(4, 4);  sub = rt(4, 5, 6, 6'b100010);
    add5 = rt(1, 2, 5, 6'b100000); sw5 = sw(5, 5);
    lw4b = lw(4, 0); mul4 = rt(1, 2, 4, 6'b011000); rd4 = rt(4, 7, 8, 6'b100000);
    lw00 = lw(0, 0); add0 = rt(0, 3, 9, 6'b100000);

    //  name        rst vld instr ck rdy out_instr vld bub sc
    v("reset",      1, 0, NOP,  0, 0, NOP,  0, 0,  0);
    // independent lw stream
    v("ind_lw16",   0, 1, l16,  1, 1, NOP,  0, 0, -1);
    v("ind_lw17",   0, 1, l17,  1, 1, l16,  1, 0, -1);
    v("ind_lw18",   0, 1, l18,  1, 1, l17,  1, 0, -1);
    v("ind_lw19",   0, 1, l19,  1, 1, l18,  1, 0, -1);
    v("ind_drain",  0, 0, NOP,  1, 1, l19,  1, 0, -1);
    v("ind_idle",   0, 0, NOP,  1, 1, NOP,  0, 0,  0);
    // RAW after lw, then RAW after R-type
    v("raw_lw",     0, 1, lw4,  1, 1, NOP,  0, 0, -1);
    v("raw_sub",    0, 1, sub,  1, 1, lw4,  1, 0, -1);
    v("raw_bub1",   0, 1, add5, 1, 0, NOP,  0, 1, -1);
    v("raw_bub2",   0, 1, add5, 1, 0, NOP,  0, 1, -1);
    v("raw_bub3",   0, 1, add5, 1, 0, NOP,  0, 1,  3);
    v("raw_issue",  0, 1, add5, 1, 1, sub,  1, 0, -1);
    v("alu_add",    0, 1, sw5,  1, 1, add5, 1, 0, -1);
    v("alu_bub1",   0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("alu_bub2",   0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("alu_bub3",   0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("alu_sw",     0, 0, NOP,  1, 1, sw5,  1, 0,  6);
    v("alu_idle",   0, 0, NOP,  1, 1, NOP,  0, 0,  6);
    // WAW reload: mul rewrites reg 4 one cycle after lw
    v("waw_lw",     0, 1, lw4b, 1, 1, NOP,  0, 0, -1);
    v("waw_mul",    0, 1, mul4, 1, 1, lw4b, 1, 0, -1);
    v("waw_rd",     0, 1, rd4,  1, 1, mul4, 1, 0, -1);
    v("waw_bub1",   0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("waw_bub2",   0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("waw_bub3",   0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("waw_issue",  0, 0, NOP,  1, 1, rd4,  1, 0,  9);
    v("waw_idle",   0, 0, NOP,  1, 1, NOP,  0, 0, -1);
    // self-read lw on reg 0, then a reader of reg 0 (reg 0 is tracked)
    v("r0_lw",      0, 1, lw00, 1, 1, NOP,  0, 0, -1);
    v("r0_add",     0, 1, add0, 1, 1, lw00, 1, 0, -1);
    v("r0_bub1",    0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("r0_bub2",    0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("r0_bub3",    0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("r0_issue",   0, 0, NOP,  1, 1, add0, 1, 0, 12);
    // reset during the second bubble of lw->sub
    v("rs_lw",      0, 1, lw4,  1, 1, NOP,  0, 0, -1);
    v("rs_sub",     0, 1, sub,  1, 1, lw4,  1, 0, -1);
    v("rs_bub1",    0, 0, NOP,  1, 0, NOP,  0, 1, -1);
    v("rs_bub2",    0, 0, NOP,  1, 0, NOP,  0, 1, 14);
    v("rs_reset",   1, 0, NOP,  0, 0, NOP,  0, 0,  0);
    v("rs_fresh",   0, 1, sub,  1, 1, NOP,  0, 0,  0);
    v("rs_issue",   0, 0, NOP,  1, 1, sub,  1, 0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].instr);
      #1;
      if (vecs[i].ck_rdy) check({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check({vecs[i].name, ".out_instr"},  out_instr,         vecs[i].o_instr);
      check({vecs[i].name, ".out_valid"},  32'(out_valid),    32'(vecs[i].o_vld));
      check({vecs[i].name, ".out_bubble"}, 32'(out_bubble),   32'(vecs[i].o_bub));
`ifdef SCHED_STALL_COUNT_EN
      if (vecs[i].sc >= 0) check({vecs[i].name, ".stall_count"}, 32'(stall_count), 32'(vecs[i].sc));
`endif
      $display("[TB] %-10s rst=%b vld=%b in=%h rdy=%b -> out=%h v=%b b=%b",
               vecs[i].name, vecs[i].rst, vecs[i].vld, vecs[i].instr, in_ready,
               out_instr, out_valid, out_bubble);
    end

    // ALU_LATENCY=1 instance: add rd=5 then sw of reg 5 -> one bubble
    drive(1, 0, NOP);
    drive(0, 1, add5);
    drive(0, 1, sw5);
    #1 check("alu1.accept_sw.in_ready", 32'(in_ready2), 32'd1);
    @(posedge clk); #1;
    check("alu1.add_out", out_instr2, add5);
    drive(0, 0, NOP);
    #1 check("alu1.stall.in_ready", 32'(in_ready2), 32'd0);
    bubbles = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_bubble2) bubbles++;
      if (out_valid2) break;
    end
    check("alu1.sw_out", out_instr2, sw5);
    check("alu1.sw_valid", 32'(out_valid2), 32'd1);
    check("alu1.bubbles", 32'(bubbles), 32'd1);
    $display("[TB] alu1 add->sw bubbles=%0d out=%h", bubbles, out_instr2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
